// File: rtl/bias_scale_pkg.sv
// Shared definitions for the bias/scale parameter store.
// Holds the word/array geometry, the loader FSM state type and the
// {layer, ch} address packing used by both the writer (this loader)
// and the reader, so the two address maps cannot drift apart.
package bias_scale_pkg;

  localparam int BIAS_WIDTH  = 32;   // multiple of 8
  localparam int SCALE_WIDTH = 16;   // multiple of 8
  localparam int LAYER_NUM   = 8;    // power of 2
  localparam int CH_NUM      = 64;   // power of 2, at most 256

  localparam int LW         = $clog2(LAYER_NUM);
  localparam int CW         = $clog2(CH_NUM);
  localparam int ADDR_WIDTH = LW + CW;

  // Bytes per record: bias bytes, then scale bytes, both LSB first.
  localparam int BB  = BIAS_WIDTH / 8;
  localparam int SB  = SCALE_WIDTH / 8;
  localparam int RB  = BB + SB;
  localparam int BCW = $clog2(RB);

  // Width of the discard byte counter; 256 records of RB bytes fit.
  localparam int DISC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_DISCARD,
    ST_DONE
  } loader_state_t;

  // RAM address is a plain bit concatenation, never a multiply.
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(
    input logic [LW-1:0] layer,
    input logic [CW-1:0] ch
  );
    return {layer, ch};
  endfunction

endpackage

// File: rtl/bias_scale_loader_word_assembler.sv
// bs_word_assembler: collects one record of RB stream bytes into a bias
// word and a scale word, little-endian.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   take       : a record byte transfers this cycle
//   data       : the byte being transferred
//   rec_bias   : assembled bias word
//   rec_scale  : assembled scale word, including the byte on 'data'
//                so it is complete on the cycle rec_done is high
//   rec_done   : the final byte of a record transfers this cycle
module bs_word_assembler
  import bias_scale_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   take,
  input  logic [7:0]             data,
  output logic [BIAS_WIDTH-1:0]  rec_bias,
  output logic [SCALE_WIDTH-1:0] rec_scale,
  output logic                   rec_done
);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(RB - 1);

  logic [BCW-1:0]         byte_cnt;
  logic [BIAS_WIDTH-1:0]  bias_q;
  logic [SCALE_WIDTH-1:0] scale_q;

  assign rec_done = take && (byte_cnt == LAST_BYTE);
  assign rec_bias = bias_q;

  // The last record byte is always the top scale lane; merge it in
  // directly so the writer can register a complete word on rec_done.
  always_comb begin
    rec_scale = scale_q;
    rec_scale[SCALE_WIDTH-8 +: 8] = data;
  end

  // Byte k of the record lands in lane k of bias, then lane k-BB of
  // scale. The counter only moves on a real transfer, so stalls hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      bias_q   <= '0;
      scale_q  <= '0;
    end else if (take) begin
      if (int'(byte_cnt) < BB) begin
        bias_q[int'(byte_cnt)*8 +: 8] <= data;
      end else begin
        scale_q[(int'(byte_cnt) - BB)*8 +: 8] <= data;
      end
      byte_cnt <= rec_done ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bias_scale_loader.sv
// bias_scale_loader: writer side of the bias/scale parameter store.
// Parses per-layer packets (layer byte, channel-count-minus-1 byte, then
// one bias+scale record per channel) from a byte stream and issues one
// RAM write per channel.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_data/s_valid    : incoming stream byte and its valid
//   s_ready           : loader accepts a byte this cycle
//   clr_mask          : clears loaded_mask
//   wr_en             : one-cycle write strobe
//   wr_addr           : {layer, ch} write address
//   wr_bias/wr_scale  : write data, held until the next write
//   busy              : a packet is in progress
//   done              : one-cycle pulse, good packet finished
//   err               : one-cycle pulse, bad header seen
//   loaded_mask       : bit i set once layer i has been loaded
module bias_scale_loader
  import bias_scale_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   clr_mask,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [BIAS_WIDTH-1:0]  wr_bias,
  output logic [SCALE_WIDTH-1:0] wr_scale,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [LAYER_NUM-1:0]   loaded_mask
);

  loader_state_t state;

  logic [7:0]             layer_q;
  logic [CW-1:0]          n1_q;
  logic [CW-1:0]          ch_q;
  logic [DISC_W-1:0]      disc_left;

  logic                   xfer;
  logic                   take;
  logic                   hdr_bad;
  logic [DISC_W-1:0]      disc_total;
  logic [LAYER_NUM-1:0]   layer_onehot;
  logic                   rec_done;
  logic [BIAS_WIDTH-1:0]  rec_bias;
  logic [SCALE_WIDTH-1:0] rec_scale;

  // Ready is gated by rst so no byte can slip in on the reset cycle.
  assign s_ready = !rst && (state != ST_DONE);
  assign busy    = (state != ST_IDLE);
  assign xfer    = s_valid && s_ready;
  assign take    = xfer && (state == ST_LOAD);

  // The full layer byte takes part in the range check; only the low LW
  // bits are used for addressing once the check has passed.
  assign hdr_bad = ({1'b0, layer_q} >= 9'(LAYER_NUM)) ||
                   ({1'b0, s_data}  >= 9'(CH_NUM));

  // Bytes to skip after a bad header, minus one: (N1+1)*RB - 1.
  assign disc_total = (DISC_W'(s_data) + DISC_W'(1)) * DISC_W'(RB) - DISC_W'(1);

  assign layer_onehot = LAYER_NUM'(1) << layer_q[LW-1:0];

  bs_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .take      (take),
    .data      (s_data),
    .rec_bias  (rec_bias),
    .rec_scale (rec_scale),
    .rec_done  (rec_done)
  );

  // Packet FSM. wr_en, done and err are registered pulses; the write of
  // the last record and done are launched on the same edge so they
  // appear together in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      layer_q     <= '0;
      n1_q        <= '0;
      ch_q        <= '0;
      disc_left   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_bias     <= '0;
      wr_scale    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      loaded_mask <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      if (clr_mask) begin
        loaded_mask <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            layer_q <= s_data;
            state   <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (xfer) begin
            n1_q <= s_data[CW-1:0];
            ch_q <= '0;
            if (hdr_bad) begin
              err       <= 1'b1;
              disc_left <= disc_total;
              state     <= ST_DISCARD;
            end else begin
              state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (rec_done) begin
            wr_en    <= 1'b1;
            wr_addr  <= pack_addr(layer_q[LW-1:0], ch_q);
            wr_bias  <= rec_bias;
            wr_scale <= rec_scale;
            if (ch_q == n1_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end
        end

        ST_DISCARD: begin
          if (xfer) begin
            if (disc_left == '0) begin
              state <= ST_IDLE;
            end else begin
              disc_left <= disc_left - 1'b1;
            end
          end
        end

        ST_DONE: begin
          // A simultaneous clr_mask wipes the other bits but this
          // layer's bit is still set.
          loaded_mask <= (clr_mask ? '0 : loaded_mask) | layer_onehot;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
